up5k_sysctl: RTL
================

// Module: up5k_sysctl
// PURPOSE
//  Clock/reset/input conditioner between SB_PLL40_PAD and the vga_6502 core. Divides the
//  PLL clock clk_4x into clk_2x and clk, and sequences sys_reset from pll_lock.
//  Debounces the PMOD2 buttons into clean levels and press/release pulses for gpio_i.
//  All state runs on clk_4x. Every clk-domain output changes at a single clk_4x edge
//  phase, so the core samples it with setup margin.
// PARAMETERS
//  LOCK_WAIT_BITS  8   width of the post-lock wait counter; wait = 2**LOCK_WAIT_BITS clk_4x cycles
//  BTN_N           3   number of button inputs
//  BTN_DEB_BITS    16  width of the debounce counter; stable time = 2**BTN_DEB_BITS clk_4x cycles
// PORTS
//  clk_4x      in   1       PLL output clock (39.75 MHz); the only clock
//  NRST        in   1       synchronous, active-low reset
//  pll_lock    in   1       PLL LOCK output, asynchronous
//  btn_in      in   BTN_N   raw buttons, active-high, asynchronous
//  clk_2x      out  1       clk_4x/2 = ph[0]
//  clk         out  1       clk_4x/4 = ph[1]; core system clock
//  sys_reset   out  1       active-high core reset, registered
//  btn_level   out  BTN_N   debounced button level
//  btn_press   out  BTN_N   rise pulse, exactly 4 clk_4x cycles (one clk period)
//  btn_release out  BTN_N   fall pulse, exactly 4 clk_4x cycles
//  seq_state   out  2       FSM state, for the LED diagnostic
// BEHAVIOUR
//  Divider
//   - 2-bit ph increments every clk_4x cycle. Power-on init 2'b00.
//   - NOT reset by NRST, so clk keeps running while the core is held in reset.
//   - Update edge: the clk_4x edge where ph==2'b11 (the falling edge of clk).
//  Sync
//   - pll_lock and each btn_in go through a 2-flop synchronizer (lock_s, btn_s).
//   - Synchronizer flops reset to 0.
//  FSM (all transitions on clk_4x)
//   - Encoding: HOLD=2'b00, WAIT=2'b01, RUN=2'b10.
//   - HOLD: cnt=0. lock_s=1 -> WAIT.
//   - WAIT: lock_s=0 -> HOLD. Otherwise cnt==all-ones -> RUN, else cnt++.
//   - RUN: lock_s=0 -> HOLD. A 1-cycle lock drop is enough and forces a full re-sequence.
//   - cnt is LOCK_WAIT_BITS wide and never wraps; it is cleared whenever the FSM is in HOLD.
//  sys_reset
//   - Deassertion: sys_reset <= (state!=RUN), updated only at the update edge.
//   - Assertion: if state leaves RUN, sys_reset rises at the next update edge (≤4 cycles).
//  NRST low
//   - Synchronous, at the next clk_4x edge: state=HOLD, cnt=0, sys_reset=1, lock_s=0,
//     btn_level=0, btn_press=0, btn_release=0, all debounce counters=0, seq_state=2'b00.
//   - Asserted mid-sequence or mid-RUN: the same values apply immediately, with no phase
//     alignment. Only deassertion of sys_reset is phase-aligned.
//  Debounce (per button)
//   - If btn_s==lvl: dcnt=0.
//   - Else dcnt++. When dcnt==all-ones, lvl<=btn_s, dcnt=0, and a pending rise or fall flag is set.
//   - btn_level, btn_press and btn_release are registered and update only at the update edge:
//     btn_level<=lvl; btn_press<=pending_rise; btn_release<=pending_fall; pending flags cleared.
//     Pulses therefore last exactly 4 clk_4x cycles.
//   - A rise and a fall both pending in one window: both pulses are issued, and btn_level shows
//     the final lvl.
//   - Buttons are independent of sys_reset and are reset only by NRST.
// STRUCTURE
//  - Package up5k_sysctl_pkg: FSM encodings, PH_UPD=2'b11.
//  - Sub-module btn_debounce: synchronizer, counter, lvl and pending flags. Instantiated
//    BTN_N times in a generate loop.
//  - FSM, divider and output registers live in the top of this block.
// TESTING (bench: LOCK_WAIT_BITS=4, BTN_DEB_BITS=3; cycle 0 = first clk_4x edge with NRST=1)
//  1. Free run, NRST toggled: clk_2x toggles every cycle, clk every 2 cycles, with no glitch or
//     stall while NRST=0.
//  2. pll_lock=1 throughout, NRST low for 5 cycles then high:
//     - lock_s=1 at cycle 2, WAIT at 3, RUN at 19, seq_state=2'b10.
//     - sys_reset=1 until the first ph==11 edge after cycle 19 (≤ cycle 23), then 0.
//  3. pll_lock low for 1 cycle at cycle 10 (during WAIT): FSM returns to HOLD, cnt=0, and RUN
//     is re-entered 16+1 cycles after lock_s recovers; sys_reset stays 1 throughout.
//  4. In RUN, pll_lock low for 1 cycle: sys_reset=1 within 2+4 cycles, followed by the full
//     scenario-2 re-sequence.
//  5. In RUN, NRST low for 1 cycle: sys_reset=1 and seq_state=00 on the very next edge;
//     sequence then repeats as in scenario 2.
//  6. btn_in[0] toggling every 3 cycles for 24 cycles, then high for 12, then low for 12:
//     - btn_level[0] rises once and falls once.
//     - Exactly one 4-cycle btn_press[0] and one 4-cycle btn_release[0], each starting at a
//       ph==11 edge.
//     - btn[1] and btn[2] outputs stay 0.
//  7. Buttons held high with NRST=0: btn_level=0 and no pulses.
//     After release of NRST: btn_level=1 after 8+2 cycles plus alignment, with one press pulse.

Source files
------------

// File: rtl/up5k_sysctl_pkg.sv
// Shared encodings for the up5k clock/reset/input conditioner.
package up5k_sysctl_pkg;

  // Power sequencer states; the encoding is visible on seq_state for the LED diagnostic.
  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_WAIT = 2'b01,
    ST_RUN  = 2'b10
  } seq_state_t;

  // Divider phase at which all clk-domain outputs are updated (falling edge of clk).
  localparam logic [1:0] PH_UPD = 2'b11;

endpackage

// File: rtl/up5k_sysctl_btn_debounce.sv
// One button: 2-flop synchronizer, stability counter, debounced level and
// pending edge flags. The pending flags are held until the parent's update
// phase consumes them, so no edge is lost between clk-domain updates.
module btn_debounce #(
  parameter int DEB_BITS = 16
) (
  input  logic clk_4x,
  input  logic NRST,
  input  logic btn_in,
  input  logic upd,
  output logic lvl,
  output logic pend_rise,
  output logic pend_fall
);

  logic                btn_m;
  logic                btn_s;
  logic [DEB_BITS-1:0] dcnt;
  logic                flip;

  // The stable level changes on the edge where a differing input has been seen for 2**DEB_BITS cycles.
  assign flip = (btn_s != lvl) && (dcnt == '1);

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk_4x) begin
    if (!NRST) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn_in;
      btn_s <= btn_m;
    end
  end

  // Stability counter: restarts whenever the input agrees with the current level.
  always_ff @(posedge clk_4x) begin
    if (!NRST) begin
      dcnt <= '0;
      lvl  <= 1'b0;
    end else if (btn_s == lvl) begin
      dcnt <= '0;
    end else if (flip) begin
      lvl  <= btn_s;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  // Pending flags: cleared when consumed at the update phase, but a new edge on that same cycle wins.
  always_ff @(posedge clk_4x) begin
    if (!NRST) begin
      pend_rise <= 1'b0;
      pend_fall <= 1'b0;
    end else begin
      pend_rise <= (pend_rise & ~upd) | (flip & btn_s);
      pend_fall <= (pend_fall & ~upd) | (flip & ~btn_s);
    end
  end

endmodule

// File: rtl/up5k_sysctl.sv
// Clock/reset/input conditioner between the PLL and the vga_6502 core.
// Divides clk_4x into clk_2x/clk, sequences sys_reset from pll_lock and
// presents debounced buttons. Every clk-domain output changes only on the
// clk_4x edge where ph==PH_UPD, i.e. on the falling edge of clk.
module up5k_sysctl
  import up5k_sysctl_pkg::*;
#(
  parameter int LOCK_WAIT_BITS = 8,
  parameter int BTN_N          = 3,
  parameter int BTN_DEB_BITS   = 16
) (
  input  logic             clk_4x,
  input  logic             NRST,
  input  logic             pll_lock,
  input  logic [BTN_N-1:0] btn_in,
  output logic             clk_2x,
  output logic             clk,
  output logic             sys_reset,
  output logic [BTN_N-1:0] btn_level,
  output logic [BTN_N-1:0] btn_press,
  output logic [BTN_N-1:0] btn_release,
  output logic [1:0]       seq_state
);

  // Divider phase; power-on value only, so clk keeps running while NRST is low.
  logic [1:0] ph = 2'b00;
  logic       upd;

  logic       lock_m;
  logic       lock_s;

  seq_state_t                state;
  seq_state_t                state_nxt;
  logic [LOCK_WAIT_BITS-1:0] cnt;
  logic [LOCK_WAIT_BITS-1:0] cnt_nxt;

  logic [BTN_N-1:0] lvl;
  logic [BTN_N-1:0] pend_rise;
  logic [BTN_N-1:0] pend_fall;

  assign clk_2x    = ph[0];
  assign clk       = ph[1];
  assign upd       = (ph == PH_UPD);
  assign seq_state = state;

  // Free-running phase counter for the clock divider.
  always_ff @(posedge clk_4x) begin
    ph <= ph + 2'd1;
  end

  // Two-stage synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk_4x) begin
    if (!NRST) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Sequencer state and post-lock wait counter.
  always_ff @(posedge clk_4x) begin
    if (!NRST) begin
      state <= ST_HOLD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sequencer next state: any lock loss forces a full re-sequence from HOLD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_HOLD: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!lock_s) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else if (cnt == '1) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Core reset: NRST asserts it at once; otherwise it follows the sequencer at the update phase only.
  always_ff @(posedge clk_4x) begin
    if (!NRST) begin
      sys_reset <= 1'b1;
    end else if (upd) begin
      sys_reset <= (state != ST_RUN);
    end
  end

  for (genvar i = 0; i < BTN_N; i++) begin : g_btn
    btn_debounce #(
      .DEB_BITS(BTN_DEB_BITS)
    ) u_deb (
      .clk_4x   (clk_4x),
      .NRST     (NRST),
      .btn_in   (btn_in[i]),
      .upd      (upd),
      .lvl      (lvl[i]),
      .pend_rise(pend_rise[i]),
      .pend_fall(pend_fall[i])
    );
  end

  // Button outputs registered at the update phase, so each pulse lasts exactly one clk period.
  always_ff @(posedge clk_4x) begin
    if (!NRST) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else if (upd) begin
      btn_level   <= lvl;
      btn_press   <= pend_rise;
      btn_release <= pend_fall;
    end
  end

endmodule
